uv_rst_gen: RTL and testbench
=============================

// Module: uv_rst_gen
// PURPOSE
//   Reset generator and sequencer. Sits upstream of the per-domain reset synchronizers.
//   Merges the POR with synchronous reset requests (watchdog, software, debug) into one reset event.
//   Stretches each event to a minimum width.
//   Releases STAGE_NUM active-low resets in a fixed order, STAGE_GAP cycles apart.
//   Each rst_out_n bit drives the async rst_n input of one domain's reset synchronizer.
// PARAMETERS
//   SRC_NUM     4   number of reset request sources (>=1)
//   HOLD_CYCLES 16  minimum reset assertion width in clk cycles (>=2)
//   STAGE_NUM   3   number of sequenced reset outputs (>=1)
//   STAGE_GAP   8   clk cycles between consecutive stage releases (>=1)
// PORTS
//   clk        in   1            free-running clock
//   rst        in   1            POR; asynchronous, active-high
//   req_i      in   SRC_NUM      reset requests, synchronous to clk, level-sensitive
//   req_mask   in   SRC_NUM      1 = ignore corresponding req_i bit
//   cause_clr  in   1            1-cycle pulse, clears rst_cause
//   rst_out_n  out  STAGE_NUM    sequenced resets, active-low, registered
//   busy       out  1            1 from reset assertion until the last stage is released
//   rst_cause  out  SRC_NUM+1    sticky cause: bit i = req_i[i], bit SRC_NUM = POR
// BEHAVIOUR
//   Reset (rst=1, async, no clock needed)
//     rst_out_n=0 (all bits), busy=1, state=HOLD, hold_cnt=0, stage_idx=0.
//     rst_cause = {1'b1, {SRC_NUM{1'b0}}}.
//   Definitions
//     act = |(req_i & ~req_mask), sampled at each rising edge.
//     All outputs are flops. No combinational path from inputs to outputs.
//   FSM states: HOLD, RELEASE, RUN.
//   HOLD
//     hold_cnt increments each cycle.
//     If act: hold_cnt<=0 and stay in HOLD (stretch).
//     Else if hold_cnt==HOLD_CYCLES-1: rst_out_n[0]<=1 and gap_cnt<=0.
//       If STAGE_NUM==1: go to RUN, busy<=0.
//       Else: go to RELEASE, stage_idx<=1.
//   RELEASE
//     gap_cnt increments each cycle.
//     When gap_cnt==STAGE_GAP-1: rst_out_n[stage_idx]<=1, gap_cnt<=0, stage_idx++.
//     When the last stage is released: go to RUN, busy<=0 on the same edge.
//   RUN
//     Outputs all 1, busy=0.
//   Request in RELEASE or RUN
//     If act: on the same edge rst_out_n<=0 (all bits), busy<=1, hold_cnt<=0, go to HOLD.
//     Partial release is discarded. The sequence restarts from stage 0.
//   Timing
//     With edge E = the first edge after rst deassertion, or the last edge with act=1:
//     stage k is released at edge E + HOLD_CYCLES - 1 + k*STAGE_GAP for POR,
//     and at E + HOLD_CYCLES + k*STAGE_GAP for a request.
//     Stages never release out of order. A released stage never glitches low except on a new reset event.
//   rst_cause
//     Each edge: rst_cause[i] <= (rst_cause[i] & ~cause_clr) | (req_i[i] & ~req_mask[i]).
//     Set wins over clear. POR bit: cleared by cause_clr, set only by rst.
//     rst_cause is held across request-triggered resets.
//   req_mask change: takes effect on the next edge; it does not abort a HOLD in progress.
//   Async rst mid-operation: all outputs return to reset values immediately.
//   Counters are sized with $clog2. No wrap occurs because every counter is bounded by its compare.
// TESTING (HOLD_CYCLES=16, STAGE_GAP=8, STAGE_NUM=3, SRC_NUM=4)
//   POR: rst 1->0, no requests.
//     -> rst_out_n 000 until edge 16; then 001@16, 011@24, 111@32.
//     -> busy falls @32. rst_cause=5'b10000.
//   RUN, req_i=4'b0010 for 1 cycle.
//     -> next edge: rst_out_n=000, busy=1, rst_cause=5'b10010.
//     -> release 001/011/111 at +16/+24/+32 edges after the request edge.
//   req_i[0] held 40 cycles starting in HOLD.
//     -> rst_out_n stays 000 throughout; stage 0 releases 16 edges after the last edge with req=1.
//   req_mask=4'b1000, req_i=4'b1000 in RUN.
//     -> rst_out_n stays 111, busy=0, rst_cause unchanged.
//   req_i[3] pulse after stage 0 but before stage 1 is released.
//     -> all 000 next edge; sequence restarts at 001 after 16 edges.
//   cause_clr=1 with req_i=4'b0100 on the same edge, cause was 5'b10001.
//     -> rst_cause=5'b00100.
//   Async rst asserted mid-RELEASE between edges.
//     -> rst_out_n=000, busy=1, rst_cause=5'b10000 immediately.

Source files
------------

// File: rtl/uv_rst_gen.sv
// uv_rst_gen: reset generator and sequencer.
// Merges the power-on reset with synchronous reset requests into a single
// reset event, stretches the event to a minimum width, then releases the
// active-low stage resets one at a time in index order, STAGE_GAP cycles apart.
// A sticky cause register records which sources have triggered a reset.
//
// Handshake note: there is no valid/ready interface here. req_i is a
// level-sensitive request sampled on every rising edge, and cause_clr is a
// single-cycle pulse that is also sampled on every edge.
//
// state_o is a debug view of the sequencer state:
// 0 = HOLD, 1 = RELEASE, 2 = RUN.
module uv_rst_gen #(
    parameter int SRC_NUM     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_NUM   = 3,
    parameter int STAGE_GAP   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SRC_NUM-1:0]   req_i,
    input  logic [SRC_NUM-1:0]   req_mask,
    input  logic                 cause_clr,
    output logic [STAGE_NUM-1:0] rst_out_n,
    output logic                 busy,
    output logic [SRC_NUM:0]     rst_cause,
    output logic [1:0]           state_o
);

    // Counter widths. The gap and stage counters need at least one bit even
    // when their parameter is 1.
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int SW = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;

    // Terminal counts for each counter.
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(STAGE_GAP - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_NUM - 1);

    // Sequencer states.
    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    logic [1:0]           state_q,     state_d;
    logic [HW-1:0]        hold_cnt_q,  hold_cnt_d;
    logic [GW-1:0]        gap_cnt_q,   gap_cnt_d;
    logic [SW-1:0]        stage_idx_q, stage_idx_d;
    logic [STAGE_NUM-1:0] rst_out_n_q, rst_out_n_d;
    logic                 busy_q,      busy_d;
    logic [SRC_NUM:0]     rst_cause_q, rst_cause_d;

    logic                 act;

    // An unmasked request is pending.
    assign act = |(req_i & ~req_mask);

    // Sequencer next state: hold stretch, staged release, and restart on request.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        stage_idx_d = stage_idx_q;
        rst_out_n_d = rst_out_n_q;
        busy_d      = busy_q;

        case (state_q)
            ST_HOLD: begin
                if (act) begin
                    // A request keeps re-arming the minimum width.
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    rst_out_n_d[0] = 1'b1;
                    gap_cnt_d      = '0;
                    if (STAGE_NUM == 1) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                    end else begin
                        state_d     = ST_RELEASE;
                        stage_idx_d = SW'(1);
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end

            ST_RELEASE: begin
                if (act) begin
                    // Drop any partial release and start over from stage 0.
                    state_d     = ST_HOLD;
                    hold_cnt_d  = '0;
                    gap_cnt_d   = '0;
                    stage_idx_d = '0;
                    rst_out_n_d = '0;
                    busy_d      = 1'b1;
                end else if (gap_cnt_q == GAP_LAST) begin
                    for (int i = 0; i < STAGE_NUM; i++) begin
                        if (stage_idx_q == SW'(i)) begin
                            rst_out_n_d[i] = 1'b1;
                        end
                    end
                    gap_cnt_d = '0;
                    if (stage_idx_q == STAGE_LAST) begin
                        state_d     = ST_RUN;
                        busy_d      = 1'b0;
                        stage_idx_d = '0;
                    end else begin
                        stage_idx_d = stage_idx_q + SW'(1);
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end

            ST_RUN: begin
                if (act) begin
                    state_d     = ST_HOLD;
                    hold_cnt_d  = '0;
                    gap_cnt_d   = '0;
                    stage_idx_d = '0;
                    rst_out_n_d = '0;
                    busy_d      = 1'b1;
                end
            end

            default: begin
                // An unreachable encoding is treated as a fresh reset event.
                state_d     = ST_HOLD;
                hold_cnt_d  = '0;
                gap_cnt_d   = '0;
                stage_idx_d = '0;
                rst_out_n_d = '0;
                busy_d      = 1'b1;
            end
        endcase
    end

    // Sticky cause bits. A set wins over a clear on the same edge, and the
    // POR bit can only be cleared here. It is set by rst alone.
    always_comb begin
        rst_cause_d                = rst_cause_q;
        rst_cause_d[SRC_NUM-1:0]   = (rst_cause_q[SRC_NUM-1:0] & ~{SRC_NUM{cause_clr}})
                                   | (req_i & ~req_mask);
        rst_cause_d[SRC_NUM]       = rst_cause_q[SRC_NUM] & ~cause_clr;
    end

    // Sequencer and cause registers, forced to the POR state asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            stage_idx_q <= '0;
            rst_out_n_q <= '0;
            busy_q      <= 1'b1;
            rst_cause_q <= {1'b1, {SRC_NUM{1'b0}}};
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            stage_idx_q <= stage_idx_d;
            rst_out_n_q <= rst_out_n_d;
            busy_q      <= busy_d;
            rst_cause_q <= rst_cause_d;
        end
    end

    assign rst_out_n = rst_out_n_q;
    assign busy      = busy_q;
    assign rst_cause = rst_cause_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_uv_rst_gen.sv
// tb_uv_rst_gen: self-checking bench for uv_rst_gen. It uses table vectors,
// hand-written corner sequences, and random stimulus checked against a
// timeline model.
module tb_uv_rst_gen;

    localparam int SRC_NUM     = 4;
    localparam int HOLD_CYCLES = 16;
    localparam int STAGE_NUM   = 3;
    localparam int STAGE_GAP   = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req_i;
    logic [3:0] req_mask;
    logic       cause_clr;
    logic [2:0] rst_out_n;
    logic       busy;
    logic [4:0] rst_cause;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;

    // Reference model: edges elapsed since the reset event plus the cause bits.
    // The POR counts as an event at a virtual edge just before the first
    // clock, so every stage k releases once elapsed reaches
    // HOLD_CYCLES + k*STAGE_GAP.
    int         m_elapsed;
    logic [4:0] m_cause;

    typedef struct {
        int         n;
        logic [3:0] req;
        logic [3:0] mask;
        logic       clr;
        logic [2:0] exp_out;
        logic       exp_busy;
        logic [4:0] exp_cause;
    } vec_t;

    vec_t vecs[$];

    uv_rst_gen #(
        .SRC_NUM    (SRC_NUM),
        .HOLD_CYCLES(HOLD_CYCLES),
        .STAGE_NUM  (STAGE_NUM),
        .STAGE_GAP  (STAGE_GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .req_mask (req_mask),
        .cause_clr(cause_clr),
        .rst_out_n(rst_out_n),
        .busy     (busy),
        .rst_cause(rst_cause),
        .state_o  (state_o)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int released(input int e);
        int r;
        if (e < HOLD_CYCLES) return 0;
        r = (e - HOLD_CYCLES) / STAGE_GAP + 1;
        if (r > STAGE_NUM) r = STAGE_NUM;
        return r;
    endfunction

    task automatic model_reset();
        m_elapsed = 0;
        m_cause   = 5'b10000;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [3:0] m, input logic c);
        logic act;
        act          = |(r & ~m);
        m_cause[3:0] = (m_cause[3:0] & ~{4{c}}) | (r & ~m);
        m_cause[4]   = m_cause[4] & ~c;
        if (act) m_elapsed = 0;
        else if (m_elapsed < 1000000) m_elapsed++;
    endtask

    task automatic check_vals(input string name, input logic [2:0] eo,
                              input logic eb, input logic [4:0] ec);
        total++;
        if (rst_out_n !== eo) begin
            bad++;
            $display("FAIL %s rst_out_n got=%b want=%b t=%0t", name, rst_out_n, eo, $time);
        end
        total++;
        if (busy !== eb) begin
            bad++;
            $display("FAIL %s busy got=%b want=%b t=%0t", name, busy, eb, $time);
        end
        total++;
        if (rst_cause !== ec) begin
            bad++;
            $display("FAIL %s rst_cause got=%b want=%b t=%0t", name, rst_cause, ec, $time);
        end
    endtask

    task automatic check_model(input string name);
        int         r;
        logic [2:0] eo;
        r  = released(m_elapsed);
        eo = 3'((1 << r) - 1);
        check_vals(name, eo, (r < STAGE_NUM), m_cause);
    endtask

    // Driver: apply the inputs for one edge, advance the model, then settle.
    task automatic step(input logic [3:0] r, input logic [3:0] m, input logic c);
        req_i     = r;
        req_mask  = m;
        cause_clr = c;
        @(posedge clk);
        model_edge(r, m, c);
        #1;
    endtask

    task automatic add(input int n, input logic [3:0] r, input logic [3:0] m, input logic c,
                       input logic [2:0] eo, input logic eb, input logic [4:0] ec);
        vec_t v;
        v.n = n; v.req = r; v.mask = m; v.clr = c;
        v.exp_out = eo; v.exp_busy = eb; v.exp_cause = ec;
        vecs.push_back(v);
    endtask

    initial begin
        // Vectors start right after the POR is released. Each entry is
        // applied for n edges and then checked.
        add(15, 4'b0000, 4'b0000, 1'b0, 3'b000, 1'b1, 5'b10000); // edge 15
        add(1,  4'b0000, 4'b0000, 1'b0, 3'b001, 1'b1, 5'b10000); // edge 16
        add(7,  4'b0000, 4'b0000, 1'b0, 3'b001, 1'b1, 5'b10000); // edge 23
        add(1,  4'b0000, 4'b0000, 1'b0, 3'b011, 1'b1, 5'b10000); // edge 24
        add(8,  4'b0000, 4'b0000, 1'b0, 3'b111, 1'b0, 5'b10000); // edge 32
        add(1,  4'b0010, 4'b0000, 1'b0, 3'b000, 1'b1, 5'b10010); // request
        add(15, 4'b0000, 4'b0000, 1'b0, 3'b000, 1'b1, 5'b10010);
        add(1,  4'b0000, 4'b0000, 1'b0, 3'b001, 1'b1, 5'b10010); // +16
        add(8,  4'b0000, 4'b0000, 1'b0, 3'b011, 1'b1, 5'b10010); // +24
        add(8,  4'b0000, 4'b0000, 1'b0, 3'b111, 1'b0, 5'b10010); // +32
        add(5,  4'b1000, 4'b1000, 1'b0, 3'b111, 1'b0, 5'b10010); // masked
        add(40, 4'b0001, 4'b0000, 1'b0, 3'b000, 1'b1, 5'b10011); // long hold
        add(15, 4'b0000, 4'b0000, 1'b0, 3'b000, 1'b1, 5'b10011);
        add(1,  4'b0000, 4'b0000, 1'b0, 3'b001, 1'b1, 5'b10011);
        add(1,  4'b1000, 4'b0000, 1'b0, 3'b000, 1'b1, 5'b11011); // abort release
        add(16, 4'b0000, 4'b0000, 1'b0, 3'b001, 1'b1, 5'b11011);
        add(16, 4'b0000, 4'b0000, 1'b0, 3'b111, 1'b0, 5'b11011);
        add(1,  4'b0000, 4'b0000, 1'b1, 3'b111, 1'b0, 5'b00000); // clear
        add(1,  4'b0001, 4'b0000, 1'b0, 3'b000, 1'b1, 5'b00001);
        add(16, 4'b0000, 4'b0000, 1'b0, 3'b001, 1'b1, 5'b00001);
        add(16, 4'b0000, 4'b0000, 1'b0, 3'b111, 1'b0, 5'b00001);
        add(3,  4'b0100, 4'b0000, 1'b0, 3'b000, 1'b1, 5'b00101);
        add(15, 4'b0100, 4'b0100, 1'b0, 3'b000, 1'b1, 5'b00101); // mask mid-hold
        add(1,  4'b0100, 4'b0100, 1'b0, 3'b001, 1'b1, 5'b00101);
        add(16, 4'b0000, 4'b0000, 1'b0, 3'b111, 1'b0, 5'b00101);

        // Reset.
        rst       = 1'b1;
        req_i     = '0;
        req_mask  = '0;
        cause_clr = 1'b0;
        model_reset();
        #2;
        check_vals("por_async", 3'b000, 1'b1, 5'b10000);
        repeat (2) @(posedge clk);
        #1;
        check_vals("por_held", 3'b000, 1'b1, 5'b10000);
        rst = 1'b0;
        model_reset();

        // Table phase.
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) step(vecs[i].req, vecs[i].mask, vecs[i].clr);
            check_vals($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_busy, vecs[i].exp_cause);
        end

        // Async reset between edges while stages are being released.
        step(4'b0001, 4'b0000, 1'b0);
        for (int k = 0; k < 20; k++) step(4'b0000, 4'b0000, 1'b0);
        check_vals("pre_async_release", 3'b001, 1'b1, 5'b00101);
        #3;
        rst = 1'b1;
        #1;
        check_vals("async_mid_release", 3'b000, 1'b1, 5'b10000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Clear and set on the same edge: the set wins, the POR bit clears.
        step(4'b0001, 4'b0000, 1'b0);
        check_vals("cause_set", 3'b000, 1'b1, 5'b10001);
        step(4'b0100, 4'b0000, 1'b1);
        check_vals("clr_vs_set", 3'b000, 1'b1, 5'b00100);

        // Random phase checked against the model each edge.
        for (int c = 0; c < 4000; c++) begin
            logic [3:0] r;
            logic [3:0] m;
            logic       cl;
            r  = ($urandom_range(0, 40) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            m  = ($urandom_range(0, 50) == 0) ? 4'($urandom_range(0, 15)) : req_mask;
            cl = ($urandom_range(0, 30) == 0);
            step(r, m, cl);
            check_model("rand");
            if ($urandom_range(0, 600) == 0) begin
                #2;
                rst = 1'b1;
                model_reset();
                #1;
                check_model("rand_async");
                @(posedge clk);
                #1;
                rst = 1'b0;
                model_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
